// File: rtl/mem_ctrl_pkg.sv
// Shared types for the memory controller: FSM states, access source codes and a grant decoder.
// A source code doubles as the bit index of that source in the pending/grant vectors.
package mem_ctrl_pkg;

    localparam int MC_WORD_W = 32;
    localparam int MC_ST_W   = 2;

    typedef enum logic [MC_ST_W-1:0] {
        MC_IDLE = 2'd0,
        MC_BUSY = 2'd1,
        MC_DONE = 2'd2
    } mc_state_e;

    typedef enum logic [1:0] {
        MC_SRC_FETCH = 2'd0,
        MC_SRC_LOAD  = 2'd1,
        MC_SRC_STORE = 2'd2
    } mc_src_e;

    function automatic mc_src_e grant_to_src(input logic [2:0] grant);
        if (grant[MC_SRC_STORE]) return MC_SRC_STORE;
        if (grant[MC_SRC_LOAD])  return MC_SRC_LOAD;
        return MC_SRC_FETCH;
    endfunction

endpackage

// File: rtl/mem_ctrl_arbiter.sv
// Fixed-priority pick over the three pending access bits: store beats load beats fetch.
module mc_arbiter
    import mem_ctrl_pkg::*;
(
    input  logic [2:0] pending,
    output logic [2:0] grant
);

    always_comb begin
        grant = '0;
        if (pending[MC_SRC_STORE])
            grant[MC_SRC_STORE] = 1'b1;
        else if (pending[MC_SRC_LOAD])
            grant[MC_SRC_LOAD] = 1'b1;
        else if (pending[MC_SRC_FETCH])
            grant[MC_SRC_FETCH] = 1'b1;
    end

endmodule

// File: rtl/mem_ctrl.sv
// Merges the cpu fetch, load and store ports onto one req/ack memory bus with a timeout,
// returning fetch/load data on registered outputs and a sticky error for misaligned or aborted accesses.
module mem_ctrl
    import mem_ctrl_pkg::*;
#(
    parameter int W       = MC_WORD_W,
    parameter int TIMEOUT = 255,
    parameter int TO_W    = 8
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         pc_en,
    input  logic [W-1:0] pc,
    output logic [W-1:0] read_inst,
    input  logic         load_en,
    input  logic [W-1:0] l_addr,
    output logic [W-1:0] l_data,
    input  logic         store_en,
    input  logic [W-1:0] s_addr,
    input  logic [W-1:0] s_data,
    output logic         stall,
    output logic         bus_err,
    output logic         mem_req,
    output logic         mem_we,
    output logic [W-1:0] mem_addr,
    output logic [W-1:0] mem_wdata,
    input  logic         mem_ack,
    input  logic [W-1:0] mem_rdata
);

    mc_state_e       state;
    mc_src_e         cur_src;
    logic [2:0]      pend_q;
    logic [2:0]      strobe;
    logic [2:0]      pend_eff;
    logic [2:0]      grant;
    logic [TO_W-1:0] to_cnt;
    logic [W-1:0]    pc_q, l_addr_q, s_addr_q, s_data_q;
    logic [W-1:0]    pc_eff, l_addr_eff, s_addr_eff, s_data_eff;
    logic [W-1:0]    sel_addr;

    // A strobe arriving in IDLE is serviced the same edge, so it bypasses the latches.
    assign strobe     = {store_en, load_en, pc_en};
    assign pend_eff   = pend_q | strobe;
    assign pc_eff     = pc_en    ? pc     : pc_q;
    assign l_addr_eff = load_en  ? l_addr : l_addr_q;
    assign s_addr_eff = store_en ? s_addr : s_addr_q;
    assign s_data_eff = store_en ? s_data : s_data_q;

    assign stall = (state != MC_IDLE) | (|pend_q) | (|strobe);

    mc_arbiter u_arbiter (
        .pending (pend_eff),
        .grant   (grant)
    );

    always_comb begin
        sel_addr = '0;
        if (grant[MC_SRC_STORE])
            sel_addr = s_addr_eff;
        else if (grant[MC_SRC_LOAD])
            sel_addr = l_addr_eff;
        else if (grant[MC_SRC_FETCH])
            sel_addr = pc_eff;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state     <= MC_IDLE;
            cur_src   <= MC_SRC_FETCH;
            pend_q    <= '0;
            to_cnt    <= '0;
            pc_q      <= '0;
            l_addr_q  <= '0;
            s_addr_q  <= '0;
            s_data_q  <= '0;
            read_inst <= '0;
            l_data    <= '0;
            bus_err   <= 1'b0;
            mem_req   <= 1'b0;
            mem_we    <= 1'b0;
            mem_addr  <= '0;
            mem_wdata <= '0;
        end else begin
            if (pc_en)
                pc_q <= pc;
            if (load_en)
                l_addr_q <= l_addr;
            if (store_en) begin
                s_addr_q <= s_addr;
                s_data_q <= s_data;
            end
            pend_q <= pend_eff & ~((state == MC_IDLE) ? grant : 3'b000);

            case (state)
                MC_IDLE: begin
                    if (|pend_eff) begin
                        cur_src <= grant_to_src(grant);
                        if (sel_addr[1:0] != 2'b00) begin
                            bus_err <= 1'b1;
                            if (grant[MC_SRC_FETCH])
                                read_inst <= '0;
                            if (grant[MC_SRC_LOAD])
                                l_data <= '0;
                            state <= MC_DONE;
                        end else begin
                            mem_req   <= 1'b1;
                            mem_we    <= grant[MC_SRC_STORE];
                            mem_addr  <= sel_addr;
                            mem_wdata <= s_data_eff;
                            to_cnt    <= '0;
                            state     <= MC_BUSY;
                        end
                    end
                end
                MC_BUSY: begin
                    // An ack on the final allowed cycle still completes the access normally.
                    if (mem_ack) begin
                        mem_req <= 1'b0;
                        if (cur_src == MC_SRC_FETCH)
                            read_inst <= mem_rdata;
                        if (cur_src == MC_SRC_LOAD)
                            l_data <= mem_rdata;
                        state <= MC_DONE;
                    end else if (to_cnt == TO_W'(TIMEOUT - 1)) begin
                        mem_req <= 1'b0;
                        bus_err <= 1'b1;
                        if (cur_src == MC_SRC_FETCH)
                            read_inst <= '0;
                        if (cur_src == MC_SRC_LOAD)
                            l_data <= '0;
                        state <= MC_DONE;
                    end else begin
                        to_cnt <= to_cnt + 1'b1;
                    end
                end
                MC_DONE: state <= MC_IDLE;
                default: state <= MC_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_mem_ctrl.sv
// Directed bench for mem_ctrl: handshake latency, wait states, arbitration order, misalignment,
// reset during an access and bus timeout (TIMEOUT shortened to 4).
module tb_mem_ctrl;

    logic        clk;
    logic        rst;
    logic        pc_en, load_en, store_en;
    logic [31:0] pc, l_addr, s_addr, s_data;
    logic [31:0] read_inst, l_data;
    logic        stall, bus_err;
    logic        mem_req, mem_we, mem_ack;
    logic [31:0] mem_addr, mem_wdata, mem_rdata;

    int errors = 0;
    int checks = 0;

    mem_ctrl #(.W(32), .TIMEOUT(4), .TO_W(8)) dut (
        .clk       (clk),
        .rst       (rst),
        .pc_en     (pc_en),
        .pc        (pc),
        .read_inst (read_inst),
        .load_en   (load_en),
        .l_addr    (l_addr),
        .l_data    (l_data),
        .store_en  (store_en),
        .s_addr    (s_addr),
        .s_data    (s_data),
        .stall     (stall),
        .bus_err   (bus_err),
        .mem_req   (mem_req),
        .mem_we    (mem_we),
        .mem_addr  (mem_addr),
        .mem_wdata (mem_wdata),
        .mem_ack   (mem_ack),
        .mem_rdata (mem_rdata)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #100000;
        $display("[TB] FAIL watchdog: observed=running expected=finished");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check_output(input string tag, input logic [31:0] obsv, input logic [31:0] expv);
        checks++;
        assert (obsv === expv) else begin
            errors++;
            $error("[TB] FAIL %s: observed=%h expected=%h", tag, obsv, expv);
        end
    endtask

    // Waits (bounded) for the next request, checks it, then acks it in its first busy cycle.
    task automatic serve(input string tag, input logic exp_we, input logic [31:0] exp_addr,
                         input logic [31:0] rdata);
        int n = 0;
        while (!mem_req && n < 10) begin
            check_output({tag, " stall while waiting"}, {31'd0, stall}, 32'd1);
            tick();
            n++;
        end
        check_output({tag, " req"}, {31'd0, mem_req}, 32'd1);
        check_output({tag, " we"}, {31'd0, mem_we}, {31'd0, exp_we});
        check_output({tag, " addr"}, mem_addr, exp_addr);
        mem_rdata = rdata;
        mem_ack   = 1'b1;
        tick();
        mem_ack   = 1'b0;
    endtask

    initial begin
        rst = 1'b1;
        pc_en = 0; load_en = 0; store_en = 0;
        pc = 0; l_addr = 0; s_addr = 0; s_data = 0;
        mem_ack = 0; mem_rdata = 0;
        #2 rst = 1'b0;
        #1;
        check_output("reset mem_req", {31'd0, mem_req}, 32'd0);
        check_output("reset stall", {31'd0, stall}, 32'd0);
        check_output("reset bus_err", {31'd0, bus_err}, 32'd0);
        check_output("reset read_inst", read_inst, 32'd0);
        check_output("reset l_data", l_data, 32'd0);
        check_output("reset mem_addr", mem_addr, 32'd0);
        tick();
        tick();
        rst = 1'b1;
        tick();

        // Fetch with zero wait states.
        pc_en = 1'b1; pc = 32'h40;
        #1 check_output("t1 stall at strobe", {31'd0, stall}, 32'd1);
        tick();
        pc_en = 1'b0;
        check_output("t1 req t+1", {31'd0, mem_req}, 32'd1);
        check_output("t1 addr", mem_addr, 32'h40);
        check_output("t1 we", {31'd0, mem_we}, 32'd0);
        mem_ack = 1'b1; mem_rdata = 32'h2408000A;
        tick();
        mem_ack = 1'b0;
        check_output("t1 read_inst t+2", read_inst, 32'h2408000A);
        check_output("t1 req dropped", {31'd0, mem_req}, 32'd0);
        check_output("t1 stall t+2", {31'd0, stall}, 32'd1);
        tick();
        check_output("t1 stall low t+3", {31'd0, stall}, 32'd0);

        // Stray ack while idle must be ignored.
        mem_ack = 1'b1; mem_rdata = 32'hDEADBEEF;
        tick();
        mem_ack = 1'b0;
        check_output("idle ack read_inst", read_inst, 32'h2408000A);
        check_output("idle ack req", {31'd0, mem_req}, 32'd0);

        // Store with three wait states; ack arrives on the last cycle before timeout.
        store_en = 1'b1; s_addr = 32'h100; s_data = 32'hCAFEF00D;
        tick();
        store_en = 1'b0;
        for (int i = 0; i < 4; i++) begin
            check_output("t2 req held", {31'd0, mem_req}, 32'd1);
            check_output("t2 we held", {31'd0, mem_we}, 32'd1);
            check_output("t2 addr held", mem_addr, 32'h100);
            check_output("t2 wdata held", mem_wdata, 32'hCAFEF00D);
            if (i == 3) mem_ack = 1'b1;
            tick();
        end
        mem_ack = 1'b0;
        check_output("t2 req dropped", {31'd0, mem_req}, 32'd0);
        check_output("t2 read_inst kept", read_inst, 32'h2408000A);
        check_output("t2 l_data kept", l_data, 32'd0);
        check_output("t2 no timeout err", {31'd0, bus_err}, 32'd0);
        tick();
        check_output("t2 stall low", {31'd0, stall}, 32'd0);

        // Simultaneous strobes: bus order store, load, fetch.
        store_en = 1'b1; s_addr = 32'h200; s_data = 32'h11112222;
        load_en  = 1'b1; l_addr = 32'h300;
        pc_en    = 1'b1; pc     = 32'h400;
        tick();
        store_en = 0; load_en = 0; pc_en = 0;
        serve("t3 store", 1'b1, 32'h200, 32'h0);
        check_output("t3 wdata", mem_wdata, 32'h11112222);
        check_output("t3 stall after store", {31'd0, stall}, 32'd1);
        serve("t3 load", 1'b0, 32'h300, 32'hAAAA5555);
        check_output("t3 stall after load", {31'd0, stall}, 32'd1);
        serve("t3 fetch", 1'b0, 32'h400, 32'h12345678);
        check_output("t3 stall third done", {31'd0, stall}, 32'd1);
        check_output("t3 l_data", l_data, 32'hAAAA5555);
        check_output("t3 read_inst", read_inst, 32'h12345678);
        tick();
        check_output("t3 stall low", {31'd0, stall}, 32'd0);

        // Misaligned load, then a normal fetch.
        load_en = 1'b1; l_addr = 32'h102;
        tick();
        load_en = 1'b0;
        check_output("t4 no req", {31'd0, mem_req}, 32'd0);
        check_output("t4 bus_err", {31'd0, bus_err}, 32'd1);
        check_output("t4 l_data zero", l_data, 32'd0);
        check_output("t4 stall in done", {31'd0, stall}, 32'd1);
        tick();
        check_output("t4 stall low", {31'd0, stall}, 32'd0);
        pc_en = 1'b1; pc = 32'h44;
        tick();
        pc_en = 1'b0;
        serve("t4 fetch", 1'b0, 32'h44, 32'h0000BEEF);
        check_output("t4 read_inst", read_inst, 32'h0000BEEF);
        check_output("t4 bus_err sticky", {31'd0, bus_err}, 32'd1);
        tick();

        // Reset asserted mid-access with a load also pending.
        pc_en = 1'b1; pc = 32'h80;
        tick();
        pc_en = 1'b0;
        load_en = 1'b1; l_addr = 32'h84;
        tick();
        load_en = 1'b0;
        check_output("t6 busy before rst", {31'd0, mem_req}, 32'd1);
        #2 rst = 1'b0;
        #1;
        check_output("t6 req cleared", {31'd0, mem_req}, 32'd0);
        check_output("t6 stall cleared", {31'd0, stall}, 32'd0);
        check_output("t6 bus_err cleared", {31'd0, bus_err}, 32'd0);
        tick();
        rst = 1'b1;
        for (int i = 0; i < 3; i++) begin
            tick();
            check_output("t6 no spurious req", {31'd0, mem_req}, 32'd0);
            check_output("t6 idle stall", {31'd0, stall}, 32'd0);
        end

        // Give read_inst a known value, then let a fetch time out.
        pc_en = 1'b1; pc = 32'h50;
        tick();
        pc_en = 1'b0;
        serve("t5 prefetch", 1'b0, 32'h50, 32'h55AA55AA);
        check_output("t5 prefetch data", read_inst, 32'h55AA55AA);
        tick();
        pc_en = 1'b1; pc = 32'h60;
        tick();
        pc_en = 1'b0;
        for (int i = 0; i < 4; i++) begin
            check_output("t5 req during wait", {31'd0, mem_req}, 32'd1);
            tick();
        end
        check_output("t5 req aborted", {31'd0, mem_req}, 32'd0);
        check_output("t5 read_inst zero", read_inst, 32'd0);
        check_output("t5 bus_err", {31'd0, bus_err}, 32'd1);
        for (int i = 0; i < 3; i++) tick();
        check_output("t5 bus_err sticky", {31'd0, bus_err}, 32'd1);
        check_output("t5 idle stall", {31'd0, stall}, 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
